// File: rtl/ofm_drain.sv
// Column-bottom collector: requantizes finished partial sums, tags tile ends,
// and buffers results in a small FIFO drained over a valid/ready interface.
module ofm_drain #(
   parameter int unsigned OWIDTH   = 24,
   parameter int unsigned QWIDTH   = 8,
   parameter int unsigned SHIFT    = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TILE_LEN = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_o,
   input  logic                       clr_o,
   input  logic [OWIDTH-1:0]          ofm,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [QWIDTH-1:0]          m_data,
   output logic                       m_last,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned CW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
   localparam int unsigned EW = QWIDTH + 1;
   localparam int unsigned TW = OWIDTH + 1;

   // Half-LSB rounding offset; zero when no shift is applied.
   localparam logic [TW-1:0]        RND  = (TW'(1) << SHIFT) >> 1;
   localparam logic signed [TW-1:0] QMAX = TW'((1 << (QWIDTH - 1)) - 1);
   localparam logic signed [TW-1:0] QMIN = ~QMAX;

   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     tile_cnt;

   logic              cap, pop, push, drop, full, tile_last;
   logic signed [TW-1:0] t_sum, q_shift;
   logic [QWIDTH-1:0] q_sat;
   logic [EW-1:0]     entry, head_n;
   logic [AW-1:0]     wr_ptr_n, rd_ptr_n;
   logic [FW-1:0]     fill_n;
   logic [CW-1:0]     tile_cnt_n;
   logic              ovf_n;

   // Round, arithmetic shift and saturate; one extra bit keeps the rounding add from wrapping.
   always_comb begin
      t_sum   = $signed({ofm[OWIDTH-1], ofm}) + $signed(RND);
      q_shift = t_sum >>> SHIFT;
      q_sat   = q_shift[QWIDTH-1:0];
      if (q_shift > QMAX)
         q_sat = QMAX[QWIDTH-1:0];
      else if (q_shift < QMIN)
         q_sat = QMIN[QWIDTH-1:0];
   end

   // Next-state for FIFO bookkeeping, tile counter and overflow flag.
   always_comb begin
      cap        = en_o & ~clr_o;
      pop        = m_valid & m_ready;
      full       = (fill == FW'(DEPTH));
      push       = cap & (~full | pop);
      drop       = cap & full & ~pop;
      tile_last  = (tile_cnt == CW'(TILE_LEN - 1));
      entry      = {q_sat, tile_last};

      wr_ptr_n   = wr_ptr;
      rd_ptr_n   = rd_ptr;
      fill_n     = fill;
      tile_cnt_n = tile_cnt;
      ovf_n      = ovf;

      if (push)
         wr_ptr_n = wr_ptr + AW'(1);
      if (pop)
         rd_ptr_n = rd_ptr + AW'(1);

      case ({push, pop})
         2'b10:   fill_n = fill + FW'(1);
         2'b01:   fill_n = fill - FW'(1);
         default: fill_n = fill;
      endcase

      if (clr_o)
         tile_cnt_n = '0;
      else if (cap)
         tile_cnt_n = tile_last ? '0 : tile_cnt + CW'(1);

      if (clr_o)
         ovf_n = 1'b0;
      else if (drop)
         ovf_n = 1'b1;

      // New head is the entry being written when it lands at the read slot.
      head_n = (push && (rd_ptr_n == wr_ptr)) ? entry : mem[rd_ptr_n];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         tile_cnt <= '0;
         ovf      <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_n;
         rd_ptr   <= rd_ptr_n;
         fill     <= fill_n;
         tile_cnt <= tile_cnt_n;
         ovf      <= ovf_n;
         m_valid  <= (fill_n != '0);
         if (fill_n != '0) begin
            m_data <= head_n[EW-1:1];
            m_last <= head_n[0];
         end
      end
   end

   // Storage array needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= entry;
   end

endmodule
